// File: rtl/m68k_wb_pkg.sv
// Shared types for the 68k DRAM posted-write buffer: FIFO entry, drain FSM
// states and the controller strobe bundle.
package m68k_wb_pkg;

    // Entries carry the widest supported address; narrower tops zero-extend.
    localparam int WB_ADDR_MAX = 32;

    typedef struct packed {
        logic [WB_ADDR_MAX-1:0] addr;
        logic [15:0]            data;
        logic                   uds_l;
        logic                   lds_l;
    } wb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DRIVE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_WR_END   = 3'd3,
        ST_RD_PASS  = 3'd4,
        ST_RD_END   = 3'd5
    } wb_state_t;

    typedef struct packed {
        logic as_l;
        logic uds_l;
        logic lds_l;
        logic we_l;
        logic sel_l;
    } wb_strobes_t;

    localparam wb_strobes_t WB_STROBES_IDLE = '1;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of posted-write entries; head is always visible on o_head.
module wb_fifo
    import m68k_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_H,
    input  logic                       i_push,
    input  wb_entry_t                  i_data,
    input  logic                       i_pop,
    output wb_entry_t                  o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge Clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/m68k_dram_write_buffer.sv
// Posted-write buffer between the 68000 bus and the DRAM controller: writes
// get an early Dtack and drain in order; reads wait until all writes drained.
module m68k_dram_write_buffer
    import m68k_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      Clock,
    input  logic                      Reset_H,
    input  logic [ADDR_W-1:0]         Address,
    input  logic [15:0]               DataIn,
    input  logic                      AS_L,
    input  logic                      UDS_L,
    input  logic                      LDS_L,
    input  logic                      WE_L,
    input  logic                      DramSelect_L,
    output logic [15:0]               DataOut,
    output logic                      Dtack_L,
    output logic [ADDR_W-1:0]         Ctl_Address,
    output logic [15:0]               Ctl_DataIn,
    output logic                      Ctl_AS_L,
    output logic                      Ctl_UDS_L,
    output logic                      Ctl_LDS_L,
    output logic                      Ctl_WE_L,
    output logic                      Ctl_DramSelect_L,
    input  logic [15:0]               Ctl_DataOut,
    input  logic                      Ctl_Dtack_L,
    output logic                      Empty_H,
    output logic [$clog2(DEPTH):0]    Count
);
    wb_state_t     r_state;
    wb_strobes_t   r_strb;
    logic [ADDR_W-1:0] r_ctl_addr;
    logic [15:0]   r_ctl_data;
    logic [15:0]   r_data_out;
    logic          r_dtack_l;
    logic          r_accepted;

    logic          w_cpu_wr;
    logic          w_cpu_rd;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    wb_entry_t     w_entry;
    wb_entry_t     w_head;
    wb_strobes_t   w_cpu_strb;

    assign w_cpu_wr   = !AS_L && !DramSelect_L && !WE_L && (!UDS_L || !LDS_L);
    assign w_cpu_rd   = !AS_L && !DramSelect_L && WE_L;
    assign w_push     = w_cpu_wr && !r_accepted && !w_full;
    assign w_pop      = (r_state == ST_WR_WAIT) && !Ctl_Dtack_L;
    assign w_entry    = '{addr: WB_ADDR_MAX'(Address), data: DataIn, uds_l: UDS_L, lds_l: LDS_L};
    assign w_cpu_strb = '{as_l: AS_L, uds_l: UDS_L, lds_l: LDS_L, we_l: WE_L, sel_l: DramSelect_L};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock   (Clock),
        .Reset_H (Reset_H),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Count)
    );

    // Drain FSM; writes always win over a pending read so ordering holds.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_state    <= ST_IDLE;
            r_strb     <= WB_STROBES_IDLE;
            r_ctl_addr <= '0;
            r_ctl_data <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_WR_DRIVE;
                    end else if (w_cpu_rd) begin
                        r_state    <= ST_RD_PASS;
                        r_strb     <= w_cpu_strb;
                        r_ctl_addr <= Address;
                    end
                end
                ST_WR_DRIVE: begin
                    r_ctl_addr <= w_head.addr[ADDR_W-1:0];
                    r_ctl_data <= w_head.data;
                    r_strb     <= '{as_l: 1'b0, uds_l: w_head.uds_l, lds_l: w_head.lds_l,
                                    we_l: 1'b0, sel_l: 1'b0};
                    r_state    <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (!Ctl_Dtack_L) begin
                        r_strb  <= WB_STROBES_IDLE;
                        r_state <= ST_WR_END;
                    end
                end
                ST_WR_END: begin
                    if (Ctl_Dtack_L) r_state <= ST_IDLE;
                end
                ST_RD_PASS: begin
                    if (AS_L) begin
                        r_strb  <= WB_STROBES_IDLE;
                        r_state <= ST_RD_END;
                    end else begin
                        r_strb     <= w_cpu_strb;
                        r_ctl_addr <= Address;
                        r_data_out <= Ctl_DataOut;
                    end
                end
                ST_RD_END: begin
                    r_strb <= WB_STROBES_IDLE;
                    if (Ctl_Dtack_L) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Dtack to the CPU: early on a push, mirrored from the controller on a read.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_accepted <= 1'b0;
            r_dtack_l  <= 1'b1;
        end else if (AS_L) begin
            r_accepted <= 1'b0;
            r_dtack_l  <= 1'b1;
        end else if (w_push) begin
            r_accepted <= 1'b1;
            r_dtack_l  <= 1'b0;
        end else if (r_state == ST_RD_PASS) begin
            r_dtack_l  <= Ctl_Dtack_L;
        end
    end

    assign DataOut          = r_data_out;
    assign Dtack_L          = r_dtack_l;
    assign Ctl_Address      = r_ctl_addr;
    assign Ctl_DataIn       = r_ctl_data;
    assign Ctl_AS_L         = r_strb.as_l;
    assign Ctl_UDS_L        = r_strb.uds_l;
    assign Ctl_LDS_L        = r_strb.lds_l;
    assign Ctl_WE_L         = r_strb.we_l;
    assign Ctl_DramSelect_L = r_strb.sel_l;
    assign Empty_H          = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_m68k_dram_write_buffer.sv
// Directed bench for the posted-write buffer with a hand-driven controller.
module tb_m68k_dram_write_buffer;
    logic        Clock;
    logic        Reset_H;
    logic [31:0] Address;
    logic [15:0] DataIn;
    logic        AS_L, UDS_L, LDS_L, WE_L, DramSelect_L;
    logic [15:0] DataOut;
    logic        Dtack_L;
    logic [31:0] Ctl_Address;
    logic [15:0] Ctl_DataIn;
    logic        Ctl_AS_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L, Ctl_DramSelect_L;
    logic [15:0] Ctl_DataOut;
    logic        Ctl_Dtack_L;
    logic        Empty_H;
    logic [2:0]  Count;

    int total = 0;
    int bad = 0;
    logic [15:0] model_mem [logic [31:0]];

    m68k_dram_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .Clock(Clock), .Reset_H(Reset_H), .Address(Address), .DataIn(DataIn),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L), .DramSelect_L(DramSelect_L),
        .DataOut(DataOut), .Dtack_L(Dtack_L), .Ctl_Address(Ctl_Address), .Ctl_DataIn(Ctl_DataIn),
        .Ctl_AS_L(Ctl_AS_L), .Ctl_UDS_L(Ctl_UDS_L), .Ctl_LDS_L(Ctl_LDS_L), .Ctl_WE_L(Ctl_WE_L),
        .Ctl_DramSelect_L(Ctl_DramSelect_L), .Ctl_DataOut(Ctl_DataOut), .Ctl_Dtack_L(Ctl_Dtack_L),
        .Empty_H(Empty_H), .Count(Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic bus_idle();
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1; DramSelect_L = 1'b1;
    endtask

    // CPU write cycle: hold strobes until Dtack_L, then end the bus cycle.
    task automatic cpu_write(input logic [31:0] a, input logic [15:0] d,
                             input logic u, input logic l, output bit ok);
        Address = a; DataIn = d; UDS_L = u; LDS_L = l; WE_L = 1'b0; DramSelect_L = 1'b0; AS_L = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Dtack_L == 1'b0) begin ok = 1'b1; break; end
        end
        bus_idle();
        tick();
    endtask

    // Controller side of one write: wait for the strobe, capture, pulse Dtack.
    task automatic serve_write(output logic [31:0] a, output logic [15:0] d,
                               output logic u, output logic l, output logic we, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Ctl_AS_L == 1'b0) begin ok = 1'b1; break; end
            tick();
        end
        a = Ctl_Address; d = Ctl_DataIn; u = Ctl_UDS_L; l = Ctl_LDS_L; we = Ctl_WE_L;
        if (ok && we == 1'b0) model_mem[a] = d;
        Ctl_Dtack_L = 1'b0;
        tick();
        Ctl_Dtack_L = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_H = 1'b1;
        repeat (3) tick();
        total++; if (Ctl_AS_L !== 1'b1) begin bad++; $display("FAIL reset_ctl_as got=%b exp=1", Ctl_AS_L); end
        total++; if (Dtack_L !== 1'b1) begin bad++; $display("FAIL reset_dtack got=%b exp=1", Dtack_L); end
        total++; if (Count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
        total++; if (Empty_H !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", Empty_H); end
        total++; if (Ctl_Address !== 32'h0 || DataOut !== 16'h0) begin bad++;
            $display("FAIL reset_regs addr=%h dout=%h exp=0/0", Ctl_Address, DataOut); end
        Reset_H = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        logic [31:0] a; logic [15:0] d; logic u, l, we; bit ok;
        Address = 32'h00F00010; DataIn = 16'hBEEF; UDS_L = 1'b0; LDS_L = 1'b0;
        WE_L = 1'b0; DramSelect_L = 1'b0; AS_L = 1'b0;
        total++; if (Dtack_L !== 1'b1) begin bad++; $display("FAIL sw_dtack_pre got=%b exp=1", Dtack_L); end
        tick();
        total++; if (Dtack_L !== 1'b0) begin bad++; $display("FAIL sw_dtack_early got=%b exp=0", Dtack_L); end
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL sw_count got=%0d exp=1", Count); end
        tick();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL sw_single_push got=%0d exp=1", Count); end
        bus_idle();
        tick();
        serve_write(a, d, u, l, we, ok);
        total++; if (!ok) begin bad++; $display("FAIL sw_timeout got=none exp=ctl_cycle"); end
        total++; if (a !== 32'h00F00010 || d !== 16'hBEEF || we !== 1'b0) begin bad++;
            $display("FAIL sw_ctl got=%h/%h we=%b exp=00f00010/beef we=0", a, d, we); end
        total++; if (Count !== 3'd0 || Empty_H !== 1'b1) begin bad++;
            $display("FAIL sw_drained count=%0d empty=%b exp=0/1", Count, Empty_H); end
    endtask

    task automatic test_ignored();
        Address = 32'h00F00030; DataIn = 16'h1234; UDS_L = 1'b0; LDS_L = 1'b0;
        WE_L = 1'b0; DramSelect_L = 1'b1; AS_L = 1'b0;
        repeat (3) tick();
        total++; if (Dtack_L !== 1'b1 || Count !== 3'd0) begin bad++;
            $display("FAIL ign_unselected dtack=%b count=%0d exp=1/0", Dtack_L, Count); end
        bus_idle();
        tick();
    endtask

    task automatic test_full();
        logic [31:0] a; logic [15:0] d; logic u, l, we; bit ok;
        logic [15:0] exp_d [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int i = 0; i < 4; i++) begin
            cpu_write(32'h00F00100 + 32'(i * 2), exp_d[i], 1'b0, 1'b0, ok);
            total++; if (!ok) begin bad++; $display("FAIL full_push%0d got=no_dtack exp=dtack", i); end
        end
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", Count); end
        Address = 32'h00F00108; DataIn = exp_d[4]; UDS_L = 1'b0; LDS_L = 1'b0;
        WE_L = 1'b0; DramSelect_L = 1'b0; AS_L = 1'b0;
        repeat (3) tick();
        total++; if (Dtack_L !== 1'b1 || Count !== 3'd4) begin bad++;
            $display("FAIL full_withheld dtack=%b count=%0d exp=1/4", Dtack_L, Count); end
        total++; if (Ctl_AS_L !== 1'b0 || Ctl_DataIn !== 16'h1111 || Ctl_Address !== 32'h00F00100) begin bad++;
            $display("FAIL full_drain0 as=%b got=%h@%h exp=0 1111@00f00100", Ctl_AS_L, Ctl_DataIn, Ctl_Address); end
        Ctl_Dtack_L = 1'b0;
        tick();
        Ctl_Dtack_L = 1'b1;
        tick();
        total++; if (Dtack_L !== 1'b0 || Count !== 3'd4) begin bad++;
            $display("FAIL full_accept5 dtack=%b count=%0d exp=0/4", Dtack_L, Count); end
        bus_idle();
        tick();
        for (int i = 1; i < 5; i++) begin
            serve_write(a, d, u, l, we, ok);
            total++; if (!ok || d !== exp_d[i] || a !== 32'h00F00100 + 32'(i * 2)) begin bad++;
                $display("FAIL full_order%0d ok=%b got=%h@%h exp=%h", i, ok, d, a, exp_d[i]); end
        end
        total++; if (Count !== 3'd0 || Empty_H !== 1'b1) begin bad++;
            $display("FAIL full_empty count=%0d empty=%b exp=0/1", Count, Empty_H); end
    endtask

    task automatic test_read_after_write();
        logic [31:0] a; logic [15:0] d; logic u, l, we; bit ok; bit seen;
        cpu_write(32'h00F00020, 16'hA5A5, 1'b0, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL raw_write got=no_dtack exp=dtack"); end
        Address = 32'h00F00020; UDS_L = 1'b0; LDS_L = 1'b0; WE_L = 1'b1; DramSelect_L = 1'b0; AS_L = 1'b0;
        tick(); tick();
        total++; if (Dtack_L !== 1'b1 || Ctl_WE_L !== 1'b0) begin bad++;
            $display("FAIL raw_read_held dtack=%b ctl_we=%b exp=1/0", Dtack_L, Ctl_WE_L); end
        serve_write(a, d, u, l, we, ok);
        total++; if (!ok || d !== 16'hA5A5) begin bad++; $display("FAIL raw_drain ok=%b got=%h exp=a5a5", ok, d); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (Ctl_AS_L == 1'b0 && Ctl_WE_L == 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        total++; if (!seen || Ctl_Address !== 32'h00F00020) begin bad++;
            $display("FAIL raw_pass seen=%b addr=%h exp=1/00f00020", seen, Ctl_Address); end
        Ctl_DataOut = model_mem.exists(Ctl_Address) ? model_mem[Ctl_Address] : 16'h0000;
        Ctl_Dtack_L = 1'b0;
        tick();
        total++; if (Dtack_L !== 1'b0 || DataOut !== 16'hA5A5) begin bad++;
            $display("FAIL raw_data dtack=%b got=%h exp=0/a5a5", Dtack_L, DataOut); end
        bus_idle();
        tick();
        total++; if (Ctl_AS_L !== 1'b1 || Dtack_L !== 1'b1) begin bad++;
            $display("FAIL raw_end ctl_as=%b dtack=%b exp=1/1", Ctl_AS_L, Dtack_L); end
        Ctl_Dtack_L = 1'b1;
        Ctl_DataOut = 16'h0000;
        tick();
        total++; if (Empty_H !== 1'b1) begin bad++; $display("FAIL raw_idle got=%b exp=1", Empty_H); end
    endtask

    task automatic test_byte_write();
        logic [31:0] a; logic [15:0] d; logic u, l, we; bit ok;
        cpu_write(32'h00F00041, 16'h00C3, 1'b1, 1'b0, ok);
        serve_write(a, d, u, l, we, ok);
        total++; if (!ok || u !== 1'b1 || l !== 1'b0 || d !== 16'h00C3) begin bad++;
            $display("FAIL byte_strobes ok=%b uds=%b lds=%b d=%h exp=1/1/0/00c3", ok, u, l, d); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok; bit seen; int strays;
        cpu_write(32'h00F00200, 16'h7777, 1'b0, 1'b0, ok);
        cpu_write(32'h00F00202, 16'h8888, 1'b0, 1'b0, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (Ctl_AS_L == 1'b0) begin seen = 1'b1; break; end
            tick();
        end
        total++; if (!seen || Count !== 3'd2) begin bad++;
            $display("FAIL rmd_setup seen=%b count=%0d exp=1/2", seen, Count); end
        Reset_H = 1'b1;
        tick();
        total++; if ({Ctl_AS_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L, Ctl_DramSelect_L} !== 5'b11111) begin bad++;
            $display("FAIL rmd_strobes got=%b exp=11111",
                     {Ctl_AS_L, Ctl_UDS_L, Ctl_LDS_L, Ctl_WE_L, Ctl_DramSelect_L}); end
        total++; if (Count !== 3'd0 || Empty_H !== 1'b1) begin bad++;
            $display("FAIL rmd_flush count=%0d empty=%b exp=0/1", Count, Empty_H); end
        Reset_H = 1'b0;
        strays = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Ctl_AS_L !== 1'b1) strays++;
        end
        total++; if (strays != 0) begin bad++; $display("FAIL rmd_no_cycles got=%0d exp=0", strays); end
    endtask

    initial begin
        Reset_H = 1'b1; Address = '0; DataIn = '0; Ctl_DataOut = '0; Ctl_Dtack_L = 1'b1;
        bus_idle();
        test_reset();
        test_single_write();
        test_ignored();
        test_full();
        test_read_after_write();
        test_byte_write();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
